// File: rtl/pipe_fetch_ctrl_pkg.sv
// Shared definitions for the fetch sequencing controller: PC mux selects,
// FSM state encoding and the redirect priority ranking.
package pipe_fetch_ctrl_pkg;

  typedef logic [2:0] pcsel_t;

  localparam pcsel_t PCSEL_SEQ  = 3'd0;
  localparam pcsel_t PCSEL_BR   = 3'd1;
  localparam pcsel_t PCSEL_JAL  = 3'd2;
  localparam pcsel_t PCSEL_JALR = 3'd3;
  localparam pcsel_t PCSEL_TRAP = 3'd4;
  localparam pcsel_t PCSEL_MRET = 3'd5;
  localparam pcsel_t PCSEL_RST  = 3'd6;
  localparam pcsel_t PCSEL_HOLD = 3'd7;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_IWAIT,
    ST_LSTALL
  } state_t;

  // Larger rank wins when two redirects compete for the pending slot.
  function automatic logic [2:0] redir_rank(input pcsel_t sel);
    case (sel)
      PCSEL_TRAP: redir_rank = 3'd5;
      PCSEL_MRET: redir_rank = 3'd4;
      PCSEL_JALR: redir_rank = 3'd3;
      PCSEL_JAL:  redir_rank = 3'd2;
      PCSEL_BR:   redir_rank = 3'd1;
      default:    redir_rank = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_fetch_ctrl_if.sv
// Signal bundle between the fetch controller, the EX stage, the instruction
// memory handshake and the fetch datapath.
interface pipe_fetch_ctrl_if
  import pipe_fetch_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic             imem_req;
  logic             imem_ready;
  logic             ex_valid;
  logic             ex_br_taken;
  logic             ex_jal;
  logic             ex_jalr;
  logic             ex_trap;
  logic             ex_mret;
  logic             ex_is_load;
  logic [4:0]       ex_rd;
  logic [4:0]       if_rs1;
  logic [4:0]       if_rs2;
  pcsel_t           pc_sel;
  logic             pc_en;
  logic             ifex_stall;
  logic             ifex_flush;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output imem_req, pc_sel, pc_en, ifex_stall, ifex_flush, flush_cnt, stall_cnt,
    input  imem_ready, ex_valid, ex_br_taken, ex_jal, ex_jalr, ex_trap, ex_mret,
    input  ex_is_load, ex_rd, if_rs1, if_rs2
  );

  modport slave (
    input  imem_req, pc_sel, pc_en, ifex_stall, ifex_flush, flush_cnt, stall_cnt,
    output imem_ready, ex_valid, ex_br_taken, ex_jal, ex_jalr, ex_trap, ex_mret,
    output ex_is_load, ex_rd, if_rs1, if_rs2
  );

endinterface

// File: rtl/pipe_fetch_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/pipe_fetch_ctrl.sv
// Fetch sequencing controller for the 3-stage RV32I pipeline: picks the PC
// source, gates the PC load and stalls or flushes the IF/EX register.
module pipe_fetch_ctrl
  import pipe_fetch_ctrl_pkg::*;
#(
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input logic              clk,
  input logic              rst,
  pipe_fetch_ctrl_if.master bus
);

  localparam logic [1:0] LCNT_INIT = 2'(LOAD_STALL - 1);

  state_t     r_state;
  state_t     w_nstate;
  pcsel_t     r_pend_sel;
  pcsel_t     w_npend_sel;
  logic       r_pend_v;
  logic       w_npend_v;
  logic [1:0] r_lcnt;
  logic [1:0] w_nlcnt;

  logic       w_redir_v;
  pcsel_t     w_redir_sel;
  logic       w_hazard;
  logic       w_new_wins;
  logic       w_best_v;
  pcsel_t     w_best_sel;
  pcsel_t     w_pc_sel;
  logic       w_pc_en;
  logic       w_stall;
  logic       w_flush;

  always_comb begin
    w_redir_sel = PCSEL_BR;
    if (bus.ex_trap)      w_redir_sel = PCSEL_TRAP;
    else if (bus.ex_mret) w_redir_sel = PCSEL_MRET;
    else if (bus.ex_jalr) w_redir_sel = PCSEL_JALR;
    else if (bus.ex_jal)  w_redir_sel = PCSEL_JAL;
  end

  assign w_redir_v = bus.ex_valid & (bus.ex_trap | bus.ex_mret | bus.ex_jalr |
                                     bus.ex_jal | bus.ex_br_taken);

  assign w_hazard = bus.ex_is_load & bus.ex_valid & (bus.ex_rd != 5'd0) &
                    ((bus.ex_rd == bus.if_rs1) | (bus.ex_rd == bus.if_rs2));

  // While waiting, a fresh redirect only displaces a lower-priority pending one.
  assign w_new_wins = w_redir_v &
                      (~r_pend_v | (redir_rank(w_redir_sel) > redir_rank(r_pend_sel)));
  assign w_best_v   = r_pend_v | w_redir_v;
  assign w_best_sel = w_new_wins ? w_redir_sel : r_pend_sel;

  always_comb begin
    w_pc_sel    = PCSEL_HOLD;
    w_pc_en     = 1'b0;
    w_stall     = 1'b0;
    w_flush     = 1'b0;
    w_nstate    = r_state;
    w_npend_sel = r_pend_sel;
    w_npend_v   = r_pend_v;
    w_nlcnt     = r_lcnt;
    case (r_state)
      ST_BOOT: begin
        w_pc_sel = PCSEL_RST;
        w_pc_en  = 1'b1;
        w_flush  = 1'b1;
        w_nstate = ST_RUN;
      end
      ST_RUN, ST_LSTALL: begin
        if (w_redir_v) begin
          w_nlcnt = 2'd0;
          if (bus.imem_ready) begin
            w_pc_sel = w_redir_sel;
            w_pc_en  = 1'b1;
            w_flush  = 1'b1;
            w_nstate = ST_RUN;
          end else begin
            w_npend_sel = w_redir_sel;
            w_npend_v   = 1'b1;
            w_stall     = 1'b1;
            w_nstate    = ST_IWAIT;
          end
        end else if (r_state == ST_LSTALL) begin
          w_stall = 1'b1;
          if (r_lcnt <= 2'd1) begin
            w_nlcnt  = 2'd0;
            w_nstate = ST_RUN;
          end else begin
            w_nlcnt = r_lcnt - 2'd1;
          end
        end else if (w_hazard) begin
          // The hazard cycle itself is the first of the LOAD_STALL bubbles.
          w_stall  = 1'b1;
          w_nlcnt  = LCNT_INIT;
          w_nstate = (LOAD_STALL > 1) ? ST_LSTALL : ST_RUN;
        end else if (!bus.imem_ready) begin
          w_stall  = 1'b1;
          w_nstate = ST_IWAIT;
        end else begin
          w_pc_sel = PCSEL_SEQ;
          w_pc_en  = 1'b1;
        end
      end
      ST_IWAIT: begin
        w_npend_sel = w_best_sel;
        w_npend_v   = w_best_v;
        if (bus.imem_ready) begin
          w_nstate = ST_RUN;
          w_pc_en  = 1'b1;
          if (w_best_v) begin
            w_pc_sel  = w_best_sel;
            w_flush   = 1'b1;
            w_npend_v = 1'b0;
          end else begin
            w_pc_sel = PCSEL_SEQ;
          end
        end else begin
          w_stall = 1'b1;
        end
      end
      default: begin
        w_nstate = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_BOOT;
      r_pend_sel <= PCSEL_SEQ;
      r_pend_v   <= 1'b0;
      r_lcnt     <= 2'd0;
    end else begin
      r_state    <= w_nstate;
      r_pend_sel <= w_npend_sel;
      r_pend_v   <= w_npend_v;
      r_lcnt     <= w_nlcnt;
    end
  end

  assign bus.imem_req   = (r_state != ST_BOOT);
  assign bus.pc_sel     = w_pc_sel;
  assign bus.pc_en      = w_pc_en;
  assign bus.ifex_stall = w_stall;
  assign bus.ifex_flush = w_flush;

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_flush & (r_state != ST_BOOT)),
    .cnt (bus.flush_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_stall),
    .cnt (bus.stall_cnt)
  );

endmodule

// File: doc/pipe_fetch_ctrl.md
Name: pipe_fetch_ctrl

Overview:
- Sequencing controller for the 3-stage (IF/EX/WB) RV32I pipeline.
- Owns the 3-bit select of the 8-input PC mux, the PC register load enable, and the IF/EX pipeline-register stall and flush.
- Resolves redirects (branch, jal, jalr, trap, mret), load-use stalls and instruction-memory wait states by fixed priority.
- Sits between the EX stage, the instruction-memory handshake and the fetch datapath.

Parameters:
- LOAD_STALL, 1, bubble cycles inserted on a load-use hazard (1..3).
- CNT_W, 16, width of the flush and stall event counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_ready  in  1  fetch data valid this cycle.
- ex_valid  in  1  EX stage holds a live instruction.
- ex_br_taken  in  1  conditional branch resolved taken in EX.
- ex_jal  in  1  jal in EX.
- ex_jalr  in  1  jalr in EX.
- ex_trap  in  1  exception or ecall in EX.
- ex_mret  in  1  mret in EX.
- ex_is_load  in  1  EX instruction is a load.
- ex_rd  in  5  EX destination register.
- if_rs1  in  5  source register 1 of the instruction in IF.
- if_rs2  in  5  source register 2 of the instruction in IF.
- pc_sel  out  3  PC mux select: 0 PC+4, 1 branch target, 2 jal target, 3 jalr target, 4 mtvec, 5 mepc, 6 reset vector, 7 hold.
- pc_en  out  1  PC register load enable.
- ifex_stall  out  1  hold the IF/EX register.
- ifex_flush  out  1  load a bubble into the IF/EX register on the next edge.
- flush_cnt  out  CNT_W  number of flushes, saturating.
- stall_cnt  out  CNT_W  number of stall cycles, saturating.

Behaviour:
- Reset:
  - State BOOT; pending register cleared; both counters 0.
  - Outputs during reset: pc_sel=6, pc_en=1, ifex_flush=1, ifex_stall=0, imem_req=0.
- Redirect qualification: a redirect input counts only when ex_valid=1.
- Redirect priority: trap(4) > mret(5) > jalr(3) > jal(2) > br_taken(1). If several are asserted, only the highest is taken.
- States: BOOT, RUN, IWAIT, LSTALL.
- BOOT:
  - One cycle: pc_sel=6, pc_en=1, ifex_flush=1.
  - Next state RUN.
  - imem_req rises in the first RUN cycle.
- RUN, imem_req=1:
  - Redirect with imem_ready=1: pc_sel=target, pc_en=1, ifex_flush=1, same cycle (zero-cycle decision, one-bubble penalty).
  - Redirect with imem_ready=0: latch the target into pend_sel/pend_v; pc_sel=7, pc_en=0; go to IWAIT.
  - No redirect, hazard: hazard = ex_is_load & ex_valid & ex_rd!=0 & (ex_rd==if_rs1 | ex_rd==if_rs2). On hazard, load the counter with LOAD_STALL-1; ifex_stall=1, pc_sel=7, pc_en=0; go to LSTALL.
  - No redirect, no hazard, imem_ready=0: pc_sel=7, pc_en=0, ifex_stall=1; go to IWAIT.
  - No redirect, no hazard, imem_ready=1: pc_sel=0, pc_en=1.
- IWAIT:
  - Hold PC; ifex_stall=1.
  - A new redirect arriving here overwrites pend_sel only if its priority is higher than the pending one.
  - On imem_ready=1:
    - pend_v=1: apply pend_sel, pc_en=1, ifex_flush=1, clear pend_v.
    - pend_v=0: pc_sel=0, pc_en=1.
  - Then return to RUN.
- LSTALL:
  - pc_sel=7, pc_en=0, ifex_stall=1; the counter decrements each cycle.
  - Counter reaching 0 returns to RUN.
  - A redirect during LSTALL aborts the stall immediately: take the RUN redirect path, clear the counter.
- Simultaneous stall and flush: ifex_flush wins over ifex_stall; they are never both 1 on the outputs.
- Counters:
  - flush_cnt increments on every cycle with ifex_flush=1 outside BOOT.
  - stall_cnt increments on every cycle with ifex_stall=1.
  - Both saturate at all-ones and do not wrap.
- Mid-operation reset: rst forces BOOT asynchronously from any state; pending redirect and counters are lost.
- Output timing: pc_sel, pc_en, ifex_stall and ifex_flush are combinational from state and inputs. State, pend_sel, pend_v and the counters are registered.

Decomposition:
- Shared package holds:
  - PC-select constants PCSEL_SEQ, PCSEL_BR, PCSEL_JAL, PCSEL_JALR, PCSEL_TRAP, PCSEL_MRET, PCSEL_RST, PCSEL_HOLD.
  - The FSM state encoding.
- One natural sub-module: sat_counter (parameter CNT_W; inputs clk, rst, inc; output cnt), instantiated twice.

Test Plan:
- Reset release: rst high 3 cycles, then low → first cycle pc_sel=6, pc_en=1, ifex_flush=1; next cycle pc_sel=0, imem_req=1.
- Taken branch with imem_ready=1: ex_valid=1, ex_br_taken=1 → same cycle pc_sel=1, ifex_flush=1; flush_cnt goes from 0 to 1.
- Redirect during a wait:
  - Stimulus: imem_ready=0, ex_jal=1 for one cycle, then ex_trap=1 for one cycle, then imem_ready=1 two cycles later.
  - Required: pc_sel=7 while waiting; on the ready cycle pc_sel=4 (trap overrides jal), ifex_flush=1.
- Load-use with LOAD_STALL=2:
  - Stimulus: ex_is_load=1, ex_rd=5, if_rs2=5.
  - Required: 2 cycles of ifex_stall=1, pc_en=0; stall_cnt=2; then pc_sel=0.
  - Repeat with ex_rd=0 → no stall.
- jalr during LSTALL: stall aborted the same cycle, pc_sel=3, ifex_flush=1, ifex_stall=0.
- Reset mid-IWAIT with pend_v=1: rst asserted asynchronously → BOOT outputs immediately; after release pc_sel=6, not the pending target.
